vls_agu: RTL and testbench

Parametrised vector load/store address-generation unit between the vector register file (VRF) and data memory. It has RD_PORTS independent load channels and one store channel. Each channel captures a vector-memory command: base, signed stride or index mode, VL and mask. It then streams per-element addresses to memory under a valid/grant handshake, tags returned load data with valid/mask/last for the VRF, and pulses done when the last element completes.

---
 rtl/vls_agu.sv | 215 +++++++++++++++++++++
 tb/tb_vls_agu.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vls_agu.sv
// Vector load/store AGU: RD_PORTS load channels plus one store channel streaming per-element addresses.
// Latency: busy and the first request one cycle after start; request/tag outputs combinational; done one cycle after the final handshake.
// Backpressure: rd_gnt/wr_gnt and ld_idx_valid/st_valid/st_idx_valid stall a channel; ld_start/st_start while busy are ignored.
// Optional feature macro: VLS_AGU_MASK_SKIP_EN drops the memory write for masked-off store elements.
module vls_agu #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int RD_PORTS = 2,
  parameter int MVL      = 64,
  parameter int STRIDE_W = 6,
  parameter int VL_W     = $clog2(MVL) + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [RD_PORTS-1:0]          ld_start,
  input  logic                         st_start,
  input  logic [VL_W-1:0]              cmd_vl,
  input  logic [ADDR_W-1:0]            cmd_base,
  input  logic [STRIDE_W-1:0]          cmd_stride,
  input  logic                         cmd_indexed,
  input  logic [MVL-1:0]               cmd_mask,
  input  logic [RD_PORTS*ADDR_W-1:0]   ld_idx,
  input  logic [RD_PORTS-1:0]          ld_idx_valid,
  output logic [RD_PORTS-1:0]          ld_idx_ready,
  output logic [RD_PORTS-1:0]          rd_req,
  output logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
  input  logic [RD_PORTS-1:0]          rd_gnt,
  input  logic [RD_PORTS-1:0]          rd_rvalid,
  input  logic [RD_PORTS*DATA_W-1:0]   rd_rdata,
  output logic [RD_PORTS-1:0]          ld_valid,
  output logic [RD_PORTS-1:0]          ld_mask,
  output logic [RD_PORTS-1:0]          ld_last,
  output logic [RD_PORTS*DATA_W-1:0]   ld_data,
  input  logic [DATA_W-1:0]            st_data,
  input  logic                         st_valid,
  output logic                         st_ready,
  input  logic [ADDR_W-1:0]            st_idx,
  input  logic                         st_idx_valid,
  output logic                         wr_en,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic [DATA_W-1:0]            wr_data,
  output logic                         wr_mask,
  input  logic                         wr_gnt,
  output logic [RD_PORTS:0]            busy,
  output logic [RD_PORTS:0]            done
);

  typedef enum logic [1:0] {LD_IDLE, LD_ISSUE, LD_WAIT_RSP} ld_state_t;
  typedef enum logic {ST_IDLE, ST_RUN} st_state_t;

  localparam logic [MVL-1:0] MASK_ONE = {{(MVL-1){1'b0}}, 1'b1};

  // Oversized vector lengths saturate at MVL before being captured.
  logic [VL_W-1:0] cmd_vl_clamp;
  assign cmd_vl_clamp = (cmd_vl > VL_W'(MVL)) ? VL_W'(MVL) : cmd_vl;

  function automatic logic [ADDR_W-1:0] sext_stride(input logic [STRIDE_W-1:0] s);
    return {{(ADDR_W-STRIDE_W){s[STRIDE_W-1]}}, s};
  endfunction

  genvar i;
  generate
    for (i = 0; i < RD_PORTS; i++) begin : g_ld
      ld_state_t           state;
      logic [VL_W-1:0]     vl_q, iss_q, rsp_q, iss_nxt, rsp_nxt;
      logic [ADDR_W-1:0]   base_q, addr_q, idx;
      logic [STRIDE_W-1:0] stride_q;
      logic [MVL-1:0]      mask_q;
      logic                indexed_q, done_q, active, req, fire, rsp, mbit;

      assign idx     = ld_idx[i*ADDR_W +: ADDR_W];
      assign active  = (state != LD_IDLE);
      // Requests stop once vl elements are out; a zero-length command never requests.
      assign req     = (state == LD_ISSUE) && (iss_q < vl_q) && (indexed_q ? ld_idx_valid[i] : 1'b1);
      assign fire    = req & rd_gnt[i];
      assign rsp     = active & rd_rvalid[i];
      assign iss_nxt = iss_q + VL_W'(fire);
      assign rsp_nxt = rsp_q + VL_W'(rsp);
      assign mbit    = (mask_q & (MASK_ONE << rsp_q)) != '0;

      assign rd_req[i]                    = req;
      assign rd_addr[i*ADDR_W +: ADDR_W]  = active ? (indexed_q ? base_q + idx : addr_q) : '0;
      assign ld_idx_ready[i]              = indexed_q & fire;
      assign ld_valid[i]                  = rsp;
      assign ld_mask[i]                   = rsp & mbit;
      assign ld_last[i]                   = rsp & (rsp_q == vl_q - VL_W'(1));
      assign ld_data[i*DATA_W +: DATA_W]  = rsp ? rd_rdata[i*DATA_W +: DATA_W] : '0;
      assign busy[i]                      = active;
      assign done[i]                      = done_q;

      // Load channel FSM: capture, issue vl addresses, then drain responses.
      always_ff @(posedge clk) begin
        if (rst) begin
          state     <= LD_IDLE;
          vl_q      <= '0;
          iss_q     <= '0;
          rsp_q     <= '0;
          base_q    <= '0;
          addr_q    <= '0;
          stride_q  <= '0;
          indexed_q <= 1'b0;
          mask_q    <= '0;
          done_q    <= 1'b0;
        end else begin
          done_q <= 1'b0;
          case (state)
            LD_IDLE: begin
              if (ld_start[i]) begin
                vl_q      <= cmd_vl_clamp;
                base_q    <= cmd_base;
                addr_q    <= cmd_base;
                stride_q  <= cmd_stride;
                indexed_q <= cmd_indexed;
                mask_q    <= cmd_mask;
                iss_q     <= '0;
                rsp_q     <= '0;
                state     <= LD_ISSUE;
              end
            end
            LD_ISSUE: begin
              iss_q <= iss_nxt;
              rsp_q <= rsp_nxt;
              if (fire) addr_q <= addr_q + sext_stride(stride_q);
              if (iss_nxt == vl_q) begin
                // A zero-latency memory may return the last response with the last grant.
                if (rsp_nxt == vl_q) begin
                  state  <= LD_IDLE;
                  done_q <= 1'b1;
                end else begin
                  state <= LD_WAIT_RSP;
                end
              end
            end
            LD_WAIT_RSP: begin
              rsp_q <= rsp_nxt;
              if (rsp_nxt == vl_q) begin
                state  <= LD_IDLE;
                done_q <= 1'b1;
              end
            end
            default: state <= LD_IDLE;
          endcase
        end
      end
    end
  endgenerate

  st_state_t           s_state;
  logic [VL_W-1:0]     s_vl_q, s_cnt_q, s_cnt_nxt;
  logic [ADDR_W-1:0]   s_base_q, s_addr_q;
  logic [STRIDE_W-1:0] s_stride_q;
  logic [MVL-1:0]      s_mask_q;
  logic                s_indexed_q, s_done_q, s_run, s_req, s_mbit;

  assign s_run     = (s_state == ST_RUN);
  assign s_req     = s_run && (s_cnt_q < s_vl_q) && st_valid && (s_indexed_q ? st_idx_valid : 1'b1);
  assign s_mbit    = (s_mask_q & (MASK_ONE << s_cnt_q)) != '0;
  assign s_cnt_nxt = s_cnt_q + VL_W'(st_ready);

`ifdef VLS_AGU_MASK_SKIP_EN
  // Masked-off elements are retired without touching memory.
  assign wr_en    = s_req & s_mbit;
  assign st_ready = s_mbit ? (s_req & wr_gnt) : s_req;
`else
  assign wr_en    = s_req;
  assign st_ready = s_req & wr_gnt;
`endif

  assign wr_addr          = s_run ? (s_indexed_q ? s_base_q + st_idx : s_addr_q) : '0;
  assign wr_data          = s_run ? st_data : '0;
  assign wr_mask          = s_run & s_mbit;
  assign busy[RD_PORTS]   = s_run;
  assign done[RD_PORTS]   = s_done_q;

  // Store channel FSM: consume vl elements from the VRF, advancing the address per consumed element.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_state     <= ST_IDLE;
      s_vl_q      <= '0;
      s_cnt_q     <= '0;
      s_base_q    <= '0;
      s_addr_q    <= '0;
      s_stride_q  <= '0;
      s_indexed_q <= 1'b0;
      s_mask_q    <= '0;
      s_done_q    <= 1'b0;
    end else begin
      s_done_q <= 1'b0;
      case (s_state)
        ST_IDLE: begin
          if (st_start) begin
            s_vl_q      <= cmd_vl_clamp;
            s_base_q    <= cmd_base;
            s_addr_q    <= cmd_base;
            s_stride_q  <= cmd_stride;
            s_indexed_q <= cmd_indexed;
            s_mask_q    <= cmd_mask;
            s_cnt_q     <= '0;
            s_state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          s_cnt_q <= s_cnt_nxt;
          if (st_ready) s_addr_q <= s_addr_q + sext_stride(s_stride_q);
          if (s_cnt_nxt == s_vl_q) begin
            s_state  <= ST_IDLE;
            s_done_q <= 1'b1;
          end
        end
        default: s_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vls_agu.sv
// Bench for vls_agu: directed commands plus randomized traffic against an element-list reference model.
// Expected addresses are computed per element from base/stride/index with modulo-2^ADDR_W arithmetic.
// A small memory model returns in-order read data a fixed number of cycles after each grant.
module tb_vls_agu;
  localparam int AW = 10, DW = 32, RP = 2, MVL = 64, SW = 6, VW = 7;

  logic clk = 1'b0;
  logic rst;
  logic [RP-1:0] ld_start;
  logic st_start;
  logic [VW-1:0] cmd_vl;
  logic [AW-1:0] cmd_base;
  logic [SW-1:0] cmd_stride;
  logic cmd_indexed;
  logic [MVL-1:0] cmd_mask;
  logic [RP*AW-1:0] ld_idx;
  logic [RP-1:0] ld_idx_valid, ld_idx_ready, rd_req, rd_gnt, rd_rvalid;
  logic [RP*AW-1:0] rd_addr;
  logic [RP*DW-1:0] rd_rdata, ld_data;
  logic [RP-1:0] ld_valid, ld_mask, ld_last;
  logic [DW-1:0] st_data, wr_data;
  logic st_valid, st_ready, st_idx_valid, wr_en, wr_mask, wr_gnt;
  logic [AW-1:0] st_idx, wr_addr;
  logic [RP:0] busy, done;

  vls_agu dut (
    .clk(clk), .rst(rst), .ld_start(ld_start), .st_start(st_start), .cmd_vl(cmd_vl),
    .cmd_base(cmd_base), .cmd_stride(cmd_stride), .cmd_indexed(cmd_indexed), .cmd_mask(cmd_mask),
    .ld_idx(ld_idx), .ld_idx_valid(ld_idx_valid), .ld_idx_ready(ld_idx_ready), .rd_req(rd_req),
    .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_rvalid(rd_rvalid), .rd_rdata(rd_rdata),
    .ld_valid(ld_valid), .ld_mask(ld_mask), .ld_last(ld_last), .ld_data(ld_data),
    .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready), .st_idx(st_idx),
    .st_idx_valid(st_idx_valid), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_mask(wr_mask), .wr_gnt(wr_gnt), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int nvec = 0, nfail = 0, cyc = 0, n_wr = 0;
  // Reference model state: per-channel element lists and progress counters.
  bit l_busy[RP], l_done[RP], l_ix[RP];
  int l_vl[RP], l_iss[RP], l_rsp[RP];
  logic [MVL-1:0] l_msk[RP];
  int l_adr[RP][MVL], l_idx[RP][MVL], l_due[RP][MVL];
  bit s_busy, s_done, s_ix;
  int s_vl, s_cnt;
  logic [MVL-1:0] s_msk;
  int s_adr[MVL], s_idx[MVL];
  logic [31:0] s_dat[MVL];
  // Pending command and environment knobs.
  logic [RP-1:0] q_ld;
  bit q_st, c_ix, gnt_all, do_rst, zchk;
  int c_vl, c_base, c_stride, lat;
  logic [MVL-1:0] c_msk;
  int c_idx[MVL];

  function automatic logic [31:0] memfn(input int a);
    return (32'(a) * 32'h0001_0193) ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic set_cmd(input int vl, input int base, input int stride, input bit ix, input logic [MVL-1:0] m);
    c_vl = vl; c_base = base; c_stride = stride; c_ix = ix; c_msk = m;
    for (int k = 0; k < MVL; k++) c_idx[k] = int'($urandom_range(2**AW - 1));
  endtask

  task automatic rand_cmd();
    int vl;
    vl = ($urandom_range(15) == 0) ? int'($urandom_range(127, 64)) : int'($urandom_range(24));
    set_cmd(vl, int'($urandom_range(2**AW - 1)), int'($urandom_range(63)) - 32, bit'($urandom_range(1)),
            {$urandom, $urandom});
  endtask

  task automatic cap_ld(input int ch);
    l_vl[ch] = (c_vl > MVL) ? MVL : c_vl;
    l_ix[ch] = c_ix; l_msk[ch] = c_msk; l_iss[ch] = 0; l_rsp[ch] = 0; l_busy[ch] = 1;
    for (int k = 0; k < MVL; k++) begin
      l_idx[ch][k] = c_idx[k];
      l_adr[ch][k] = (c_ix ? (c_base + c_idx[k]) : (c_base + k * c_stride)) & (2**AW - 1);
    end
  endtask

  task automatic cap_st();
    s_vl = (c_vl > MVL) ? MVL : c_vl;
    s_ix = c_ix; s_msk = c_msk; s_cnt = 0; s_busy = 1;
    for (int k = 0; k < MVL; k++) begin
      s_idx[k] = c_idx[k];
      s_adr[k] = (c_ix ? (c_base + c_idx[k]) : (c_base + k * c_stride)) & (2**AW - 1);
      s_dat[k] = $urandom;
    end
  endtask

  // One clock: drive at negedge, compare 1 ns later, advance the model, wait for posedge.
  task automatic tick();
    bit rv[RP], g[RP], iv[RP], lreq[RP];
    bit sv, siv, sg, sreq, mb, swe, srdy, dn;
    int kr, ki, ks;
    @(negedge clk);
    rst = do_rst;
    ld_start = q_ld; st_start = q_st; q_ld = '0; q_st = 0;
    cmd_vl = VW'(c_vl); cmd_base = AW'(c_base); cmd_stride = SW'(c_stride);
    cmd_indexed = c_ix; cmd_mask = c_msk;
    for (int ch = 0; ch < RP; ch++) begin
      kr = (l_rsp[ch] < MVL) ? l_rsp[ch] : MVL - 1;
      ki = (l_iss[ch] < MVL) ? l_iss[ch] : MVL - 1;
      rv[ch] = l_busy[ch] && (l_rsp[ch] < l_iss[ch]) && (l_due[ch][kr] <= cyc);
      g[ch] = gnt_all || ($urandom_range(3) != 0);
      iv[ch] = ($urandom_range(3) != 0);
      rd_rvalid[ch] = rv[ch];
      rd_rdata[ch*DW +: DW] = rv[ch] ? memfn(l_adr[ch][kr]) : $urandom;
      rd_gnt[ch] = g[ch];
      ld_idx_valid[ch] = iv[ch];
      ld_idx[ch*AW +: AW] = AW'(l_idx[ch][ki]);
      lreq[ch] = l_busy[ch] && (l_iss[ch] < l_vl[ch]) && (!l_ix[ch] || iv[ch]);
    end
    ks = (s_cnt < MVL) ? s_cnt : MVL - 1;
    sv = gnt_all || ($urandom_range(3) != 0);
    siv = ($urandom_range(3) != 0);
    sg = gnt_all || ($urandom_range(3) != 0);
    st_valid = sv; st_idx_valid = siv; wr_gnt = sg;
    st_data = s_dat[ks]; st_idx = AW'(s_idx[ks]);
    sreq = s_busy && (s_cnt < s_vl) && sv && (!s_ix || siv);
    mb = s_msk[ks];
`ifdef VLS_AGU_MASK_SKIP_EN
    swe = sreq && mb;
    srdy = mb ? (sreq && sg) : sreq;
`else
    swe = sreq;
    srdy = sreq && sg;
`endif
    #1;
    if (!do_rst) begin
      for (int ch = 0; ch < RP; ch++) begin
        kr = (l_rsp[ch] < MVL) ? l_rsp[ch] : MVL - 1;
        ki = (l_iss[ch] < MVL) ? l_iss[ch] : MVL - 1;
        chk("rd_req", 64'(rd_req[ch]), 64'(lreq[ch]));
        if (lreq[ch]) chk("rd_addr", 64'(rd_addr[ch*AW +: AW]), 64'(l_adr[ch][ki]));
        chk("ld_idx_ready", 64'(ld_idx_ready[ch]), 64'(lreq[ch] && g[ch] && l_ix[ch]));
        chk("ld_valid", 64'(ld_valid[ch]), 64'(rv[ch]));
        if (rv[ch]) begin
          chk("ld_data", 64'(ld_data[ch*DW +: DW]), 64'(memfn(l_adr[ch][kr])));
          chk("ld_mask", 64'(ld_mask[ch]), 64'(l_msk[ch][kr]));
          chk("ld_last", 64'(ld_last[ch]), 64'(l_rsp[ch] == l_vl[ch] - 1));
        end
        chk("ld_busy", 64'(busy[ch]), 64'(l_busy[ch]));
        chk("ld_done", 64'(done[ch]), 64'(l_done[ch]));
      end
      chk("wr_en", 64'(wr_en), 64'(swe));
      chk("st_ready", 64'(st_ready), 64'(srdy));
      if (swe) begin
        chk("wr_addr", 64'(wr_addr), 64'(s_adr[ks]));
        chk("wr_data", 64'(wr_data), 64'(s_dat[ks]));
        chk("wr_mask", 64'(wr_mask), 64'(mb));
      end
      chk("st_busy", 64'(busy[RP]), 64'(s_busy));
      chk("st_done", 64'(done[RP]), 64'(s_done));
      if (wr_en === 1'b1) n_wr++;
      if (zchk) begin
        chk("z_rd", 64'({rd_req, rd_addr, ld_idx_ready}), 64'(0));
        chk("z_ld", 64'({ld_valid, ld_mask, ld_last}), 64'(0));
        chk("z_ld_data", 64'(ld_data), 64'(0));
        chk("z_wr", 64'({st_ready, wr_en, wr_mask, wr_addr}), 64'(0));
        chk("z_wr_data", 64'(wr_data), 64'(0));
        chk("z_busy_done", 64'({busy, done}), 64'(0));
      end
    end
    if (do_rst) begin
      for (int ch = 0; ch < RP; ch++) begin
        l_busy[ch] = 0; l_done[ch] = 0; l_iss[ch] = 0; l_rsp[ch] = 0;
      end
      s_busy = 0; s_done = 0; s_cnt = 0;
    end else begin
      for (int ch = 0; ch < RP; ch++) begin
        dn = 0;
        if (l_busy[ch]) begin
          if (lreq[ch] && g[ch]) begin
            l_due[ch][l_iss[ch]] = cyc + lat;
            l_iss[ch]++;
          end
          if (rv[ch]) l_rsp[ch]++;
          if (l_iss[ch] == l_vl[ch] && l_rsp[ch] == l_vl[ch]) begin
            l_busy[ch] = 0; dn = 1;
          end
        end else if (ld_start[ch]) begin
          cap_ld(ch);
        end
        l_done[ch] = dn;
      end
      dn = 0;
      if (s_busy) begin
        if (srdy) s_cnt++;
        if (s_cnt == s_vl) begin
          s_busy = 0; dn = 1;
        end
      end else if (st_start) begin
        cap_st();
      end
      s_done = dn;
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic run_idle(input int budget);
    int n;
    n = 0;
    tick();
    while ((l_busy[0] || l_busy[1] || s_busy || l_done[0] || l_done[1] || s_done) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_within_budget", 64'(n < budget), 64'(1));
  endtask

  initial begin
    rst = 1'b1; ld_start = '0; st_start = 0; cmd_vl = '0; cmd_base = '0; cmd_stride = '0;
    cmd_indexed = 0; cmd_mask = '0; ld_idx = '0; ld_idx_valid = '0; rd_gnt = '0; rd_rvalid = '0;
    rd_rdata = '0; st_data = '0; st_valid = 0; st_idx = '0; st_idx_valid = 0; wr_gnt = 0;
    q_ld = '0; q_st = 0; gnt_all = 0; lat = 2; zchk = 0; do_rst = 1;
    s_busy = 0; s_done = 0; s_cnt = 0; s_vl = 0; s_ix = 0; s_msk = '0;
    for (int ch = 0; ch < RP; ch++) begin
      l_busy[ch] = 0; l_done[ch] = 0; l_iss[ch] = 0; l_rsp[ch] = 0; l_vl[ch] = 0; l_ix[ch] = 0; l_msk[ch] = '0;
      for (int k = 0; k < MVL; k++) begin
        l_adr[ch][k] = 0; l_idx[ch][k] = 0; l_due[ch][k] = 0;
      end
    end
    for (int k = 0; k < MVL; k++) begin
      s_adr[k] = 0; s_idx[k] = 0; s_dat[k] = '0;
    end
    set_cmd(0, 0, 0, 0, '0);
    tick(); tick();
    do_rst = 0; zchk = 1;
    tick();
    zchk = 0;

    // Strided load, grants every cycle, 2-cycle memory: 100,103,106,109.
    gnt_all = 1; lat = 2;
    set_cmd(4, 100, 3, 0, 64'hB);
    q_ld = 2'b01;
    run_idle(100);

    // Negative stride wrapping below zero: 2,1,0,1023.
    set_cmd(4, 2, -1, 0, 64'hF);
    q_ld = 2'b10;
    run_idle(100);

    // Indexed store with index/grant bubbles: 15,10,17.
    gnt_all = 0;
    set_cmd(3, 10, 0, 1, 64'h7);
    c_idx[0] = 5; c_idx[1] = 0; c_idx[2] = 7;
    q_st = 1;
    run_idle(200);

    // Store with mask 0101: write count depends on the skip option.
    gnt_all = 1; n_wr = 0;
    set_cmd(4, 200, 1, 0, 64'b0101);
    q_st = 1;
    run_idle(100);
`ifdef VLS_AGU_MASK_SKIP_EN
    chk("mask_skip_writes", 64'(n_wr), 64'(2));
`else
    chk("mask_all_writes", 64'(n_wr), 64'(4));
`endif

    // Concurrent channels with different vl; a re-start on busy channel 1 is ignored.
    gnt_all = 0; lat = 3;
    set_cmd(5, 300, 2, 0, {$urandom, $urandom});
    q_ld = 2'b01; tick();
    set_cmd(9, 400, -3, 1, {$urandom, $urandom});
    q_ld = 2'b10; tick();
    set_cmd(7, 500, 1, 0, {$urandom, $urandom});
    q_st = 1; tick();
    tick();
    set_cmd(20, 900, 5, 0, {$urandom, $urandom});
    q_ld = 2'b10;
    run_idle(500);

    // Zero-length commands: one busy cycle, no requests, then done.
    set_cmd(0, 33, 1, 0, '1);
    q_ld = 2'b01; q_st = 1;
    run_idle(20);

    // Oversized vl saturates at MVL.
    set_cmd(100, 700, 1, 0, {$urandom, $urandom});
    q_ld = 2'b01;
    run_idle(1000);

    // Reset while element 3 of a load is issuing; nothing may leak out afterwards.
    gnt_all = 1; lat = 2;
    set_cmd(8, 600, 1, 0, '1);
    q_ld = 2'b01; tick();
    for (int n = 0; n < 20 && l_iss[0] < 3; n++) tick();
    do_rst = 1; tick();
    do_rst = 0; zchk = 1; tick();
    zchk = 0;
    repeat (4) tick();
    set_cmd(3, 50, 2, 0, 64'h5);
    q_ld = 2'b01;
    run_idle(100);

    // Random mixed traffic.
    gnt_all = 0; lat = int'($urandom_range(3, 1));
    for (int t = 0; t < 1500; t++) begin
      if ($urandom_range(9) == 0) begin
        int w;
        w = int'($urandom_range(2));
        rand_cmd();
        if (w < RP) q_ld[w] = 1'b1;
        else q_st = 1;
      end
      tick();
    end
    run_idle(3000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
